// File: rtl/freq_est_frame.sv
// freq_est_frame: per-frame peak magnitude and hysteretic threshold-crossing count,
// with an external threshold or one derived from the previous frame's peak.
module freq_est_frame #(
  parameter int W            = 16,
  parameter int FRAME_LEN    = 256,
  parameter int CNT_W        = 16,
  parameter int THRESH_SHIFT = 2,
  parameter int HYST_EN      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i_x,
  input  logic             i_v,
  input  logic             i_restart,
  input  logic             i_thr_mode,
  input  logic [W-1:0]     i_thr_ext,
  output logic [CNT_W-1:0] o_count,
  output logic [W-1:0]     o_peak,
  output logic [W-1:0]     o_thr_out,
  output logic             o_vout
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [W-1:0] MAG_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAG_MIN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic {S_REARM = 1'b0, S_ARMED = 1'b1} state_t;
  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [W-1:0]     r_peak_acc, r_prev_peak, r_thr_cur;
  logic [CNT_W-1:0] r_cnt_acc, r_count;
  logic [W-1:0]     r_peak, r_thr_out;
  logic             r_vout;
  logic             w_accept, w_first, w_last, w_gt, w_lo, w_inc;
  logic [W-1:0]     w_thr_ad, w_thr, w_neg_thr, w_mag, w_peak_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  assign w_accept   = i_v & ~i_restart;
  assign w_first    = r_idx == '0;
  assign w_last     = r_idx == IW'(FRAME_LEN - 1);
  assign w_thr_ad   = $signed(r_prev_peak) >>> THRESH_SHIFT;
  // The first sample of a frame is judged against the threshold being loaded now
  assign w_thr      = w_first ? (i_thr_mode ? i_thr_ext : w_thr_ad) : r_thr_cur;
  assign w_neg_thr  = -w_thr;
  assign w_mag      = (i_x == MAG_MIN) ? MAG_MAX : (i_x[W-1] ? -i_x : i_x);
  assign w_peak_nxt = (w_mag > r_peak_acc) ? w_mag : r_peak_acc;
  assign w_gt       = $signed(i_x) > $signed(w_thr);
  assign w_lo       = (HYST_EN != 0) ? ($signed(i_x) < $signed(w_neg_thr)) : ~w_gt;
  assign w_cnt_nxt  = (w_inc && ~&r_cnt_acc) ? r_cnt_acc + CNT_W'(1) : r_cnt_acc;
  assign o_count    = r_count;
  assign o_peak     = r_peak;
  assign o_thr_out  = r_thr_out;
  assign o_vout     = r_vout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_REARM;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (i_restart)                 w_state_nxt = S_REARM;
    else if (i_v)                  w_state_nxt = (r_state == S_ARMED) ? (w_gt ? S_REARM : S_ARMED)
                                                                     : (w_lo ? S_ARMED : S_REARM);
  end
  always_comb begin
    w_inc = w_accept && (r_state == S_ARMED) && w_gt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_peak_acc  <= '0;
      r_cnt_acc   <= '0;
      r_prev_peak <= '0;
      r_thr_cur   <= '0;
      r_count     <= '0;
      r_peak      <= '0;
      r_thr_out   <= '0;
      r_vout      <= 1'b0;
    end else begin
      r_vout <= w_accept && w_last;
      if (i_restart) begin
        r_idx       <= '0;
        r_peak_acc  <= '0;
        r_cnt_acc   <= '0;
        r_prev_peak <= '0;
      end else if (i_v) begin
        if (w_first) r_thr_cur <= w_thr;
        if (w_last) begin
          r_count     <= w_cnt_nxt;
          r_peak      <= w_peak_nxt;
          r_thr_out   <= w_thr;
          r_prev_peak <= w_peak_nxt;
          r_idx       <= '0;
          r_cnt_acc   <= '0;
          r_peak_acc  <= '0;
        end else begin
          r_idx      <= r_idx + IW'(1);
          r_cnt_acc  <= w_cnt_nxt;
          r_peak_acc <= w_peak_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_freq_est_frame.sv
// tb_freq_est_frame: directed table, corner sequences and random stimulus for three
// freq_est_frame configurations, checked against a frame-level behavioural model.
module tb_freq_est_frame;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, thr_ext;
  logic        v, restart, thr_mode;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  logic [15:0] pk [3];
  logic [15:0] th [3];
  logic        vo [3];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  freq_est_frame #(.W(16), .FRAME_LEN(8), .CNT_W(16), .THRESH_SHIFT(2), .HYST_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .i_x(x), .i_v(v), .i_restart(restart), .i_thr_mode(thr_mode),
    .i_thr_ext(thr_ext), .o_count(cnt0), .o_peak(pk[0]), .o_thr_out(th[0]), .o_vout(vo[0]));
  freq_est_frame #(.W(16), .FRAME_LEN(8), .CNT_W(16), .THRESH_SHIFT(2), .HYST_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .i_x(x), .i_v(v), .i_restart(restart), .i_thr_mode(thr_mode),
    .i_thr_ext(thr_ext), .o_count(cnt1), .o_peak(pk[1]), .o_thr_out(th[1]), .o_vout(vo[1]));
  freq_est_frame #(.W(16), .FRAME_LEN(12), .CNT_W(2), .THRESH_SHIFT(2), .HYST_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .i_x(x), .i_v(v), .i_restart(restart), .i_thr_mode(thr_mode),
    .i_thr_ext(thr_ext), .o_count(cnt2), .o_peak(pk[2]), .o_thr_out(th[2]), .o_vout(vo[2]));

  int flen [3] = '{8, 8, 12};
  bit hy   [3] = '{1'b1, 1'b0, 1'b1};
  int cap  [3] = '{65535, 65535, 3};
  int m_idx [3], m_pk [3], m_prev [3], m_thr [3], m_n [3];
  bit m_armed [3];
  int e_cnt [3], e_pk [3], e_thr [3];
  bit e_v [3];

  typedef struct {int x; bit v; bit vo; int cnt; int pk; int thr;} vec_t;
  vec_t tv [9];

  function automatic int act_cnt(int c);
    return c == 0 ? int'(cnt0) : c == 1 ? int'(cnt1) : int'(cnt2);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_idx[c] = 0; m_pk[c] = 0; m_prev[c] = 0; m_thr[c] = 0; m_n[c] = 0; m_armed[c] = 0;
      e_cnt[c] = 0; e_pk[c] = 0; e_thr[c] = 0; e_v[c] = 0;
    end
  endtask

  task automatic model_edge();
    int xi, mag;
    xi  = int'($signed(x));
    mag = (xi == -32768) ? 32767 : (xi < 0 ? -xi : xi);
    for (int c = 0; c < 3; c++) begin
      e_v[c] = 0;
      if (restart) begin
        m_idx[c] = 0; m_pk[c] = 0; m_prev[c] = 0; m_n[c] = 0; m_armed[c] = 0;
      end else if (v) begin
        if (m_idx[c] == 0) m_thr[c] = thr_mode ? int'(thr_ext) : m_prev[c] / 4;
        if (mag > m_pk[c]) m_pk[c] = mag;
        if (m_armed[c] && xi > m_thr[c]) begin
          m_n[c]++;
          m_armed[c] = 0;
        end else if (!m_armed[c] && (hy[c] ? xi < -m_thr[c] : xi <= m_thr[c])) m_armed[c] = 1;
        m_idx[c]++;
        if (m_idx[c] == flen[c]) begin
          e_cnt[c]  = m_n[c] < cap[c] ? m_n[c] : cap[c];
          e_pk[c]   = m_pk[c];
          e_thr[c]  = m_thr[c];
          e_v[c]    = 1;
          m_prev[c] = m_pk[c];
          m_idx[c] = 0; m_n[c] = 0; m_pk[c] = 0;
        end
      end
    end
  endtask

  task automatic cmp_model();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("u%0d vout", c), int'(vo[c]), int'(e_v[c]));
      chk($sformatf("u%0d count", c), act_cnt(c), e_cnt[c]);
      chk($sformatf("u%0d peak", c), int'(pk[c]), e_pk[c]);
      chk($sformatf("u%0d thr_out", c), int'(th[c]), e_thr[c]);
    end
  endtask

  task automatic step(int xi, bit vi, bit ri);
    x = 16'(xi); v = vi; restart = ri;
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  initial begin
    int hs [8] = '{-150, 150, 50, 150, 50, 150, -150, 150};
    int f1 [8] = '{100, 4000, -300, 200, -100, 300, -200, 100};
    int f2 [8] = '{-800, 800, -800, 800, -1200, 1200, -1200, 1200};
    for (int i = 0; i < 8; i++)
      tv[i] = '{(i % 2) ? 200 : -200, 1'b1, i == 7, i == 7 ? 4 : 0, i == 7 ? 200 : 0, i == 7 ? 100 : 0};
    tv[8] = '{0, 1'b0, 1'b0, 4, 200, 100};
    rst_n = 1'b0; x = '0; v = 1'b0; restart = 1'b0; thr_mode = 1'b1; thr_ext = 16'd100;
    model_reset();
    #3;
    cmp_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // basic frame from the table
    for (int i = 0; i < 9; i++) begin
      step(tv[i].x, tv[i].v, 1'b0);
      chk($sformatf("tab%0d vout", i), int'(vo[0]), int'(tv[i].vo));
      chk($sformatf("tab%0d count", i), int'(cnt0), tv[i].cnt);
      chk($sformatf("tab%0d peak", i), int'(pk[0]), tv[i].pk);
      chk($sformatf("tab%0d thr", i), int'(th[0]), tv[i].thr);
    end
    // hysteresis vs plain re-arm
    for (int i = 0; i < 8; i++) step(hs[i], 1'b1, 1'b0);
    chk("hyst1 count", int'(cnt0), 2);
    chk("hyst0 count", int'(cnt1), 4);
    chk("hyst vout", int'(vo[0]), 1);
    // adaptive threshold
    step(0, 1'b0, 1'b1);
    thr_mode = 1'b0;
    for (int i = 0; i < 8; i++) step(f1[i], 1'b1, 1'b0);
    chk("adapt1 peak", int'(pk[0]), 4000);
    chk("adapt1 thr", int'(th[0]), 0);
    for (int i = 0; i < 8; i++) step(f2[i], 1'b1, 1'b0);
    chk("adapt2 thr", int'(th[0]), 1000);
    chk("adapt2 count", int'(cnt0), 2);
    chk("adapt2 peak", int'(pk[0]), 1200);
    // magnitude and count saturation
    thr_mode = 1'b1;
    step(0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step((i % 2) ? 200 : (i == 0 ? -32768 : -200), 1'b1, 1'b0);
      if (i == 7) begin
        chk("sat peak", int'(pk[0]), 32767);
        chk("sat u0 count", int'(cnt0), 4);
      end
    end
    chk("sat u2 vout", int'(vo[2]), 1);
    chk("sat u2 count", int'(cnt2), 3);
    chk("sat u2 peak", int'(pk[2]), 32767);
    // gaps in valid
    step(0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step((i % 2) ? 200 : -200, 1'b1, 1'b0);
      if (i == 3) repeat (3) begin
        step(0, 1'b0, 1'b0);
        chk("gap vout", int'(vo[0]), 0);
      end
    end
    chk("gap vout8", int'(vo[0]), 1);
    chk("gap count", int'(cnt0), 4);
    chk("gap peak", int'(pk[0]), 200);
    step(0, 1'b0, 1'b0);
    chk("gap vout after", int'(vo[0]), 0);
    // restart mid-frame in adaptive mode
    thr_mode = 1'b0;
    for (int i = 0; i < 5; i++) step((i % 2) ? 300 : -300, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1);
    chk("restart vout", int'(vo[0]), 0);
    for (int i = 0; i < 8; i++) step((i % 2) ? 300 : -300, 1'b1, 1'b0);
    chk("restart frame vout", int'(vo[0]), 1);
    chk("restart frame thr", int'(th[0]), 0);
    chk("restart frame peak", int'(pk[0]), 300);
    // async reset mid-frame
    for (int i = 0; i < 3; i++) step((i % 2) ? 300 : -300, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst count", int'(cnt0), 0);
    chk("arst peak", int'(pk[0]), 0);
    cmp_model();
    repeat (2) begin
      @(posedge clk);
      #1 cmp_model();
    end
    rst_n = 1'b1;
    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r, xi;
      r  = $urandom_range(0, 19);
      xi = (r == 0) ? -32768 : (r == 1) ? 32767 : int'($urandom_range(0, 6000)) - 3000;
      thr_mode = 1'($urandom_range(0, 1));
      thr_ext  = 16'($urandom_range(0, 2000));
      step(xi, $urandom_range(0, 9) < 8, $urandom_range(0, 59) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
